// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared memory port: round-robin on ties, one transaction
// in flight, registered memory-side fields, and a timeout abort when memory never responds.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    state_e            state_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              gnt0_q, gnt1_q, done0_q, done1_q, err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic tie_d;
    logic pick1_d;

    // On a tie the port that was not served last wins; last_q=1 means port 1.
    assign tie_d   = req0 & req1;
    assign pick1_d = req1 & (~req0 | ~last_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        state_q     <= pick1_d ? BUSY1 : BUSY0;
                        if (tie_d) last_q <= pick1_d;
                        gnt0_q      <= ~pick1_d;
                        gnt1_q      <= pick1_d;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= pick1_d ? we1 : we0;
                        mem_addr_q  <= pick1_d ? addr1 : addr0;
                        mem_wdata_q <= pick1_d ? wdata1 : wdata0;
                    end
                end
                BUSY0, BUSY1: begin
                    // Completion takes priority over the timeout in the same cycle.
                    if (mem_ready) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (state_q == BUSY1) begin
                            done1_q <= 1'b1;
                            if (!mem_we_q) rdata1_q <= mem_rdata;
                        end else begin
                            done0_q <= 1'b1;
                            if (!mem_we_q) rdata0_q <= mem_rdata;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (state_q == BUSY1) begin
                            done1_q <= 1'b1;
                            err1_q  <= 1'b1;
                        end else begin
                            done0_q <= 1'b1;
                            err0_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: port 0 is the multicycle core (fetch, load and store) and port 1 is the program loader/DMA.
- Serialises one transaction at a time, using round-robin arbitration on ties.
- Registers the winning request onto the memory side and waits a variable number of cycles for completion.
- Aborts with an error if memory does not respond within TIMEOUT cycles.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ready (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req0  in  1  port 0 request; addr0/we0/wdata0 are valid while high
- we0  in  1  port 0 write enable (1 = write, 0 = read)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  one-cycle pulse: port 0 request captured
- done0  out  1  one-cycle pulse: port 0 transaction finished (ok or error)
- err0  out  1  one-cycle pulse, coincident with done0: timeout abort
- rdata0  out  DATA_W  port 0 read data; held until the next port 0 read completes
- req1, we1, addr1, wdata1, gnt1, done1, err1, rdata1: same as port 0, for port 1
- mem_req  out  1  memory transaction active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completes the transaction in this cycle (valid only while mem_req=1)
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last=1, timeout counter=0.
  - All outputs are 0, including rdata0/rdata1 and mem_*.
  - Reset asserted mid-transaction drops mem_req immediately; no done is issued.
- States: IDLE, BUSY0, BUSY1. All outputs are registered.
- IDLE:
  - Sample req0/req1 at the clock edge.
  - Only one requester high: that port wins.
  - Both high: the port not equal to last wins; last is updated to the winner.
  - Next state is BUSY_w. Load mem_we/mem_addr/mem_wdata from the winner, set mem_req=1, and pulse gnt_w=1 for exactly that first BUSY cycle.
  - Neither high: stay in IDLE with mem_req=0.
- BUSY_w:
  - The memory-side fields stay frozen; requester inputs are ignored.
  - Dropping req_w does not cancel the transaction.
  - Count increments each cycle mem_ready=0.
  - mem_ready=1: go to IDLE and clear mem_req and the counter. Pulse done_w=1 for one cycle. On a read, rdata_w <= mem_rdata; on a write, rdata_w is unchanged.
  - mem_ready=0 with count == TIMEOUT-1: go to IDLE, clear mem_req, pulse done_w=1 and err_w=1; rdata_w is unchanged.
  - mem_ready=1 in the timeout cycle: completion wins and err_w stays 0.
- Latency:
  - req sampled at edge N gives gnt at N+1; with mem_ready high that cycle, done appears at N+2.
  - Minimum occupancy is 2 cycles per transaction, with 1 IDLE cycle between transactions.
- The requester must drop req in the cycle done is high. A req still high at the next edge is treated as a new request.
- A loser of a tie keeps req high and is granted on the next IDLE sample. Fairness: neither port waits more than one other-port transaction.
- At most one of gnt0/gnt1, one of done0/done1 and one of err0/err1 is high in any cycle.
- There is no address or width transformation; fields pass through unchanged.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x100; memory returns 0xDEADBEEF with 0 wait states. Required: gnt0 the cycle after the req sample, mem_addr=0x100; done0 the next cycle with rdata0=0xDEADBEEF; mem_req high exactly 1 cycle.
- Tie: req0=req1=1 held continuously from reset, 3 transactions each. Required: grants in order 0,1,0,1,0,1; no two gnt pulses in the same cycle.
- Wait states: port 1 writes addr1=0x40, wdata1=0x12345678, with mem_ready delayed 5 cycles. Required: mem_we=1 and fields stable for 6 cycles; single done1; rdata1 unchanged; err1=0.
- Timeout: TIMEOUT=16, mem_ready held 0. Required: mem_req high for 16 cycles, then done0=err0=1 for one cycle; state returns to IDLE; a following req0 is served normally.
- Ready on the last cycle: mem_ready=1 exactly in cycle 16. Required: done0=1, err0=0, and rdata0 updated.
- Reset mid-transaction: rst=0 on cycle 3 of BUSY1. Required: mem_req=0 immediately and all outputs 0; after release, the first tie goes to port 0.
